iommu_msi_ptw: RTL and testbench
================================

# iommu_msi_ptw

MSI page-table walker for the IOMMU translation path. It receives a guest-physical page number together with the device context's MSI fields (`msiptp`, `msi_addr_mask`, `msi_addr_pattern`), decides whether the access targets a virtual interrupt file, and fetches and checks the MSI PTE from memory. It returns either a write-through SPA PPN, an MRIF descriptor, a "not MSI" miss, or a fault cause in the IOMMU CAUSE encoding. It sits between the DC/PC context stage and the second-stage walker and owns one memory read port.

## Interface
- `PLEN`, 56: physical address width of `mem_addr_o`.
- `MRIF_EN`, 1: MRIF-mode PTEs are supported. When 0, an MRIF PTE is treated as misconfigured.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. Asynchronous, active-low.
- `req_valid_i` / `req_ready_o`  in/out  1: request handshake.
- `req_gppn_i`  in  52: guest-physical page number, GPA[63:12].
- `req_write_i`  in  1: access is a write.
- `msiptp_i`, `msi_mask_i`, `msi_pattern_i`  in  64 each: DC fields with `msiptp_t`, `msi_addr_mask_t` and `msi_addr_pattern_t` layouts.
- `flush_i`  in  1: abort the current walk.
- `mem_req_o`  out  1: memory read request; `mem_gnt_i`  in  1: request granted.
- `mem_addr_o`  out  PLEN: read address, 8-byte aligned.
- `mem_rvalid_i`  in  1: read data valid; `mem_rdata_i`  in  64: read data; `mem_err_i`  in  1: read error, qualified by `mem_rvalid_i`.
- `rsp_valid_o` / `rsp_ready_i`  out/in  1: response handshake.
- `rsp_hit_o`  out  1: address is MSI-translated. When 0 and `rsp_fault_o`=0, the access continues on the normal translation path.
- `rsp_fault_o`  out  1: fault; `rsp_cause_o`  out  12: fault CAUSE.
- `rsp_mode_o`  out  2: PTE mode, `msi_pte_mode_e`.
- `rsp_ppn_o`  out  47: WT mode: PTE ppn[43:0] zero-extended. MRIF mode: MRIF address[53:7].
- `rsp_nppn_o`  out  44: MRIF notice PPN; `rsp_nid_o`  out  11: MRIF notice ID, {nid_10, nid_9_0}.

## Operation
- FSM states: IDLE, RD0_REQ, RD0_WAIT, RD1_REQ, RD1_WAIT, RESP, DRAIN.
- IDLE: `req_ready_o` = !`flush_i`. On handshake, capture all request and DC inputs.
- Pre-checks on the captured request, evaluated in this priority order; each goes to RESP with no memory access:
  1. `msiptp.mode`==0 → miss.
  2. `msiptp.mode`∉{0,1} → fault 259 (DDT_ENTRY_MISCONFIGURED).
  3. (gppn & ~mask) ≠ (pattern & ~mask) → miss.
  4. `req_write_i`=0 → hit, fault 5 (LD_ACCESS_FAULT).
  5. Otherwise → RD0_REQ.
- IMSIC number: the bits of gppn selected by mask, packed into a contiguous field starting at bit 0, LSB first (extract_imsic_num).
- PTE address: A = ({msiptp.ppn, 12'b0} + (imsic << 4)) mod 2^PLEN. Word 1 is read at A+8.
- RD*_REQ: `mem_req_o`=1 with a stable address until `mem_gnt_i`, then go to the matching WAIT state. Only one read is outstanding at a time.
- Checks on word 0, in priority order:
  - `mem_err_i` → fault 261.
  - v=0 → fault 262.
  - m∈{00,10} → fault 263.
  - WT: reserved bits [9:3] or [62:54] nonzero → fault 263. Otherwise the response is hit, ppn = rdata[53:10].
  - MRIF: if `MRIF_EN`=0 or reserved bits [6:3] or [62:54] are nonzero → fault 263. Otherwise latch ppn = rdata[53:7] and go to RD1_REQ.
  - The c bit is ignored.
- Checks on word 1:
  - `mem_err_i` → fault 261.
  - Reserved bits [59:54] or [63:61] nonzero → fault 263.
  - Otherwise the response is hit, mode MRIF, nppn = rdata[53:10], nid = {rdata[60], rdata[9:0]}.
- Every fault after the MSI match asserts `rsp_hit_o`=1.
- RESP: `rsp_*` held stable with `rsp_valid_o`=1 until `rsp_ready_i`, then IDLE.
- Flush handling:
  - In IDLE or RESP: go to IDLE and drop the response.
  - In RD*_REQ: deassert `mem_req_o` in the same cycle and go to IDLE. If `mem_gnt_i` is high in that cycle, go to DRAIN instead.
  - In RD*_WAIT: go to DRAIN. DRAIN waits for `mem_rvalid_i`, discards the data, then goes to IDLE.
  - `req_ready_o`=0 in DRAIN.

## Timing
- Reset values: state IDLE; `req_ready_o`=1 (with `flush_i` low); every other output is 0.
- `mem_req_o` is registered from state. It is asserted the cycle after a request is accepted.
- Response latency:
  - Pre-check result: `rsp_valid_o` in cycle N+1 for a request accepted in cycle N.
  - WT with gnt in the request cycle and rvalid one cycle later: accept N, req N+1, rvalid N+2, `rsp_valid_o` N+3.
  - MRIF: two extra cycles at minimum.
- `rsp_valid_o` stays high while `rsp_ready_i`=0. The response fields do not change.
- `mem_rvalid_i` outside RD*_WAIT or DRAIN is ignored.
- Asserting `rst_ni` low mid-walk returns to IDLE asynchronously. Any outstanding memory read is the memory side's responsibility.

## Test plan
- WT hit: msiptp={mode 1, ppn 0x80000}, mask 0x7, pattern 0x28000, gppn 0x28005, write; word0 0x48D1407 → `mem_addr_o`=0x80000050; response hit, mode 11, ppn 0x12345, no fault; `rsp_valid_o` 3 cycles after accept (zero-wait memory).
- Non-contiguous mask: mask 0x5, gppn 0x28005 → imsic 3, `mem_addr_o`=0x80000030. Pattern mismatch (gppn 0x29005, mask 0x7) → miss next cycle, `mem_req_o` never asserted.
- Pre-check faults: read with a matching address → cause 5 with hit; msiptp.mode 2 → cause 259.
- MRIF: word0 m=01, v=1; word1 nid_10=1, nid_9_0=0x155, nppn 0xABC → two reads (A, A+8); nid 0x555, nppn 0xABC. Same stimulus with `MRIF_EN`=0 → cause 263 after one read.
- PTE faults: v=0 → 262; m=10 → 263; reserved bit 5 set in a WT PTE → 263; `mem_err_i` on word1 → 261.
- Flush in RD0_WAIT followed by rvalid 3 cycles later → no response, `req_ready_o` low until the cycle after rvalid. Hold `rsp_ready_i` low 5 cycles in RESP → outputs stable throughout.

Source files
------------

// File: rtl/iommu_msi_ptw.sv
// MSI page-table walker: matches a GPA against the device context's MSI
// window, fetches the one- or two-word MSI PTE and returns a write-through
// SPA PPN, an MRIF descriptor, a "not MSI" miss or an IOMMU fault cause.
module iommu_msi_ptw #(
  parameter int unsigned PLEN    = 56,
  parameter bit          MRIF_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [51:0]     req_gppn_i,
  input  logic            req_write_i,
  input  logic [63:0]     msiptp_i,
  input  logic [63:0]     msi_mask_i,
  input  logic [63:0]     msi_pattern_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [PLEN-1:0] mem_addr_o,
  input  logic            mem_rvalid_i,
  input  logic [63:0]     mem_rdata_i,
  input  logic            mem_err_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_hit_o,
  output logic            rsp_fault_o,
  output logic [11:0]     rsp_cause_o,
  output logic [1:0]      rsp_mode_o,
  output logic [46:0]     rsp_ppn_o,
  output logic [43:0]     rsp_nppn_o,
  output logic [10:0]     rsp_nid_o
);

  typedef enum logic [2:0] {
    IDLE, RD0_REQ, RD0_WAIT, RD1_REQ, RD1_WAIT, RESP, DRAIN
  } state_e;

  typedef enum logic [1:0] {
    MSI_MODE_NONE = 2'b00,
    MSI_MODE_MRIF = 2'b01,
    MSI_MODE_WT   = 2'b11
  } msi_pte_mode_e;

  localparam logic [11:0] CAUSE_LD_ACCESS    = 12'd5;
  localparam logic [11:0] CAUSE_DDT_MISCONF  = 12'd259;
  localparam logic [11:0] CAUSE_PTE_LD_FAULT = 12'd261;
  localparam logic [11:0] CAUSE_PTE_INVALID  = 12'd262;
  localparam logic [11:0] CAUSE_PTE_MISCONF  = 12'd263;
  localparam logic [PLEN-1:0] WORD1_OFS      = PLEN'(8);

  // Gather the gppn bits selected by the mask into a dense field, LSB first.
  function automatic logic [51:0] extract_imsic_num(input logic [51:0] gppn,
                                                    input logic [51:0] mask);
    logic [51:0] num;
    logic [5:0]  idx;
    num = '0;
    idx = '0;
    for (int i = 0; i < 52; i++) begin
      if (mask[i]) begin
        num[idx] = gppn[i];
        idx      = idx + 6'd1;
      end
    end
    return num;
  endfunction

  state_e          state_q, state_d;
  logic [PLEN-1:0] addr_q, addr_d;
  logic            hit_q, hit_d, fault_q, fault_d;
  logic [11:0]     cause_q, cause_d;
  msi_pte_mode_e   mode_q, mode_d;
  logic [46:0]     ppn_q, ppn_d;
  logic [43:0]     nppn_q, nppn_d;
  logic [10:0]     nid_q, nid_d;

  logic [3:0]  req_mode;
  logic [51:0] mask52, pattern52, imsic;
  logic        addr_match;
  logic [63:0] pte_addr_full;
  logic        w0_fault, w1_fault;
  logic [11:0] w0_cause, w1_cause;
  logic [1:0]  pte_m;
  logic        unused_bits;

  assign req_mode      = msiptp_i[63:60];
  assign mask52        = msi_mask_i[51:0];
  assign pattern52     = msi_pattern_i[51:0];
  assign addr_match    = ((req_gppn_i & ~mask52) == (pattern52 & ~mask52));
  assign imsic         = extract_imsic_num(req_gppn_i, mask52);
  assign pte_addr_full = {8'b0, msiptp_i[43:0], 12'b0} + {8'b0, imsic, 4'b0};
  assign pte_m         = mem_rdata_i[2:1];
  assign unused_bits   = ^{msiptp_i[59:44], msi_mask_i[63:52], msi_pattern_i[63:52],
                           pte_addr_full};

  // First PTE word: error, valid, mode and reserved-bit checks (c bit ignored).
  always_comb begin
    w0_fault = 1'b1;
    w0_cause = CAUSE_PTE_MISCONF;
    if (mem_err_i) begin
      w0_cause = CAUSE_PTE_LD_FAULT;
    end else if (!mem_rdata_i[0]) begin
      w0_cause = CAUSE_PTE_INVALID;
    end else if (pte_m == MSI_MODE_WT) begin
      w0_fault = (|mem_rdata_i[9:3]) || (|mem_rdata_i[62:54]);
    end else if (pte_m == MSI_MODE_MRIF) begin
      w0_fault = !MRIF_EN || (|mem_rdata_i[6:3]) || (|mem_rdata_i[62:54]);
    end
  end

  // Second (MRIF notice) PTE word: error and reserved-bit checks.
  always_comb begin
    w1_fault = mem_err_i || (|mem_rdata_i[59:54]) || (|mem_rdata_i[63:61]);
    w1_cause = mem_err_i ? CAUSE_PTE_LD_FAULT : CAUSE_PTE_MISCONF;
  end

  // Walk sequencing: pre-checks on accept, PTE reads, response hold and flush.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    fault_d = fault_q;
    cause_d = cause_q;
    mode_d  = mode_q;
    ppn_d   = ppn_q;
    nppn_d  = nppn_q;
    nid_d   = nid_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          hit_d   = 1'b0;
          fault_d = 1'b0;
          cause_d = '0;
          mode_d  = MSI_MODE_NONE;
          ppn_d   = '0;
          nppn_d  = '0;
          nid_d   = '0;
          addr_d  = pte_addr_full[PLEN-1:0];
          state_d = RESP;
          if (req_mode == 4'd0) begin
            hit_d = 1'b0;
          end else if (req_mode != 4'd1) begin
            fault_d = 1'b1;
            cause_d = CAUSE_DDT_MISCONF;
          end else if (!addr_match) begin
            hit_d = 1'b0;
          end else if (!req_write_i) begin
            hit_d   = 1'b1;
            fault_d = 1'b1;
            cause_d = CAUSE_LD_ACCESS;
          end else begin
            state_d = RD0_REQ;
          end
        end
      end
      RD0_REQ, RD1_REQ: begin
        if (flush_i) begin
          state_d = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_d = (state_q == RD0_REQ) ? RD0_WAIT : RD1_WAIT;
        end
      end
      RD0_WAIT: begin
        if (flush_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          hit_d   = 1'b1;
          state_d = RESP;
          if (w0_fault) begin
            fault_d = 1'b1;
            cause_d = w0_cause;
          end else if (pte_m == MSI_MODE_WT) begin
            mode_d = MSI_MODE_WT;
            ppn_d  = {3'b0, mem_rdata_i[53:10]};
          end else begin
            ppn_d   = mem_rdata_i[53:7];
            addr_d  = addr_q + WORD1_OFS;
            state_d = RD1_REQ;
          end
        end
      end
      RD1_WAIT: begin
        if (flush_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          hit_d   = 1'b1;
          state_d = RESP;
          if (w1_fault) begin
            fault_d = 1'b1;
            cause_d = w1_cause;
            ppn_d   = '0;
          end else begin
            mode_d = MSI_MODE_MRIF;
            nppn_d = mem_rdata_i[53:10];
            nid_d  = {mem_rdata_i[60], mem_rdata_i[9:0]};
          end
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset returns to an idle, all-zero view.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= '0;
      mode_q  <= MSI_MODE_NONE;
      ppn_q   <= '0;
      nppn_q  <= '0;
      nid_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      mode_q  <= mode_d;
      ppn_q   <= ppn_d;
      nppn_q  <= nppn_d;
      nid_q   <= nid_d;
    end
  end

  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign mem_req_o   = ((state_q == RD0_REQ) || (state_q == RD1_REQ)) && !flush_i;
  assign mem_addr_o  = addr_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_hit_o   = hit_q;
  assign rsp_fault_o = fault_q;
  assign rsp_cause_o = cause_q;
  assign rsp_mode_o  = mode_q;
  assign rsp_ppn_o   = ppn_q;
  assign rsp_nppn_o  = nppn_q;
  assign rsp_nid_o   = nid_q;

endmodule

// File: tb/tb_iommu_msi_ptw.sv
// Scoreboard bench for iommu_msi_ptw: directed cases from the test plan,
// then randomized walks against a behavioural model with a random memory.
module tb_iommu_msi_ptw;
  localparam int PLEN    = 56;
  localparam bit MRIF_EN = 1'b1;

  logic            clk, rst_n;
  logic            req_valid_i, req_ready_o, req_write_i, flush_i;
  logic [51:0]     req_gppn_i;
  logic [63:0]     msiptp_i, msi_mask_i, msi_pattern_i;
  logic            mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [PLEN-1:0] mem_addr_o;
  logic [63:0]     mem_rdata_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_hit_o, rsp_fault_o;
  logic [11:0]     rsp_cause_o;
  logic [1:0]      rsp_mode_o;
  logic [46:0]     rsp_ppn_o;
  logic [43:0]     rsp_nppn_o;
  logic [10:0]     rsp_nid_o;

  iommu_msi_ptw #(.PLEN(PLEN), .MRIF_EN(MRIF_EN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_gppn_i(req_gppn_i), .req_write_i(req_write_i),
    .msiptp_i(msiptp_i), .msi_mask_i(msi_mask_i), .msi_pattern_i(msi_pattern_i),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_fault_o(rsp_fault_o), .rsp_cause_o(rsp_cause_o),
    .rsp_mode_o(rsp_mode_o), .rsp_ppn_o(rsp_ppn_o),
    .rsp_nppn_o(rsp_nppn_o), .rsp_nid_o(rsp_nid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic        fault;
    logic [11:0] cause;
    logic [1:0]  mode;
    logic [46:0] ppn;
    logic [43:0] nppn;
    logic [10:0] nid;
  } rsp_t;

  typedef struct {
    logic [51:0] gppn;
    logic        write;
    logic [63:0] msiptp, mask, pattern, w0, w1;
    logic        err0, err1;
  } txn_t;

  rsp_t        exp_rsp_q[$];
  logic [55:0] exp_addr_q[$];
  logic [63:0] mem_data[logic [55:0]];
  bit          mem_errs[logic [55:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int gnt_pct = 100, dly_min = 0, dly_max = 0, ready_pct = 100;
  bit hold_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] got,
                             input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic rsp_t packRsp();
    return {rsp_hit_o, rsp_fault_o, rsp_cause_o, rsp_mode_o, rsp_ppn_o, rsp_nppn_o, rsp_nid_o};
  endfunction

  // Reference model: what the walker should answer, and which addresses it reads.
  function automatic rsp_t model(input txn_t t, output int nreads, output logic [55:0] a);
    rsp_t r;
    logic [51:0] m52, p52;
    longint unsigned imsic, weight;
    logic [63:0] full;
    r = '0; nreads = 0;
    m52 = t.mask[51:0]; p52 = t.pattern[51:0];
    imsic = 0; weight = 1;
    for (int i = 0; i < 52; i++) begin
      if (m52[i]) begin
        if (t.gppn[i]) imsic += weight;
        weight = weight * 2;
      end
    end
    full = ({20'b0, t.msiptp[43:0]} * 64'd4096) + imsic * 16;
    a = full[55:0];
    if (t.msiptp[63:60] == 4'd0) return r;
    if (t.msiptp[63:60] != 4'd1) begin r.fault = 1; r.cause = 12'd259; return r; end
    if ((t.gppn & ~m52) != (p52 & ~m52)) return r;
    r.hit = 1;
    if (!t.write) begin r.fault = 1; r.cause = 12'd5; return r; end
    nreads = 1;
    if (t.err0) begin r.fault = 1; r.cause = 12'd261; return r; end
    if (!t.w0[0]) begin r.fault = 1; r.cause = 12'd262; return r; end
    if (t.w0[2:1] == 2'b11) begin
      if (t.w0[9:3] != 0 || t.w0[62:54] != 0) begin r.fault = 1; r.cause = 12'd263; return r; end
      r.mode = 2'b11; r.ppn = {3'b0, t.w0[53:10]};
      return r;
    end
    if (t.w0[2:1] != 2'b01 || !MRIF_EN || t.w0[6:3] != 0 || t.w0[62:54] != 0) begin
      r.fault = 1; r.cause = 12'd263; return r;
    end
    nreads = 2;
    if (t.err1) begin r.fault = 1; r.cause = 12'd261; return r; end
    if (t.w1[59:54] != 0 || t.w1[63:61] != 0) begin r.fault = 1; r.cause = 12'd263; return r; end
    r.mode = 2'b01; r.ppn = t.w0[53:7]; r.nppn = t.w1[53:10]; r.nid = {t.w1[60], t.w1[9:0]};
    return r;
  endfunction

  function automatic txn_t mkTxn(input logic [51:0] gppn, input logic write,
                                 input logic [63:0] msiptp, mask, pattern, w0, w1,
                                 input logic err0, err1);
    txn_t t;
    t.gppn = gppn; t.write = write; t.msiptp = msiptp; t.mask = mask;
    t.pattern = pattern; t.w0 = w0; t.w1 = w1; t.err0 = err0; t.err1 = err1;
    return t;
  endfunction

  function automatic txn_t randTxn(input int idx);
    txn_t t;
    int r;
    logic [51:0] rnd;
    t.msiptp = '0;
    r = $urandom_range(99, 0);
    t.msiptp[63:60] = (r < 6) ? 4'd0 : (r < 10) ? 4'($urandom_range(15, 2)) : 4'd1;
    t.msiptp[43:0] = {12'($urandom), 16'(1000 + idx), 16'($urandom)};
    t.mask    = {58'b0, 6'($urandom)};
    t.pattern = {$urandom, $urandom};
    rnd       = 52'({$urandom, $urandom});
    t.gppn    = (t.pattern[51:0] & ~t.mask[51:0]) | (rnd & t.mask[51:0]);
    if ($urandom_range(9, 0) == 0) t.gppn[$urandom_range(51, 6)] ^= 1'b1;
    t.write = ($urandom_range(9, 0) != 0);
    t.w0 = {$urandom, $urandom};
    r = $urandom_range(99, 0);
    t.w0[2:1] = (r < 45) ? 2'b11 : (r < 90) ? 2'b01 : (r < 95) ? 2'b00 : 2'b10;
    t.w0[0]   = ($urandom_range(9, 0) != 0);
    if ($urandom_range(4, 0) != 0) begin
      t.w0[62:54] = '0;
      if (t.w0[2:1] == 2'b11) t.w0[9:3] = '0;
      else t.w0[6:3] = '0;
    end
    t.w1 = {$urandom, $urandom};
    if ($urandom_range(4, 0) != 0) begin t.w1[59:54] = '0; t.w1[63:61] = '0; end
    t.err0 = ($urandom_range(15, 0) == 0);
    t.err1 = ($urandom_range(15, 0) == 0);
    return t;
  endfunction

  // Issue one request; expectations are queued before the handshake.
  task automatic applyStimulus(input txn_t t, input bit push_rsp, input int exp_lat);
    rsp_t e;
    int nr, guard, lat;
    logic [55:0] a;
    e = model(t, nr, a);
    if (nr >= 1) begin mem_data[a] = t.w0; mem_errs[a] = t.err0; exp_addr_q.push_back(a); end
    if (nr == 2) begin
      mem_data[a + 56'd8] = t.w1; mem_errs[a + 56'd8] = t.err1;
      exp_addr_q.push_back(a + 56'd8);
    end
    if (push_rsp) exp_rsp_q.push_back(e);
    @(negedge clk);
    req_valid_i = 1'b1; req_gppn_i = t.gppn; req_write_i = t.write;
    msiptp_i = t.msiptp; msi_mask_i = t.mask; msi_pattern_i = t.pattern;
    guard = 0;
    while (!req_ready_o && guard < 2000) begin @(negedge clk); guard++; end
    if (guard >= 2000) begin n_checks++; $display("[TB] FAIL req_accept: ready 0 required 1"); end
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    if (exp_lat > 0) begin
      lat = 1;
      while (!rsp_valid_o && lat < 50) begin @(negedge clk); lat++; end
      checkOutput("latency", 128'(lat), 128'(exp_lat));
    end
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((exp_rsp_q.size() != 0 || exp_addr_q.size() != 0) && guard < 5000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 5000) begin
      n_checks++;
      $display("[TB] FAIL drain_timeout: rsp left %0d addr left %0d required 0",
               exp_rsp_q.size(), exp_addr_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: random grant, one outstanding read, random read latency.
  initial begin
    bit pending = 0;
    int delay = 0;
    logic [55:0] paddr = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
    forever begin
      @(negedge clk);
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
      if (pending) begin
        if (delay == 0) begin
          mem_rvalid_i = 1'b1;
          if (mem_data.exists(paddr)) begin
            mem_rdata_i = mem_data[paddr]; mem_err_i = mem_errs[paddr];
          end else begin
            mem_rdata_i = {$urandom, $urandom}; mem_err_i = 1'b1;
          end
          pending = 0;
        end else delay--;
      end else if (mem_req_o && ($urandom_range(99, 0) < gnt_pct)) begin
        mem_gnt_i = 1'b1; paddr = mem_addr_o; pending = 1;
        delay = $urandom_range(dly_max, dly_min);
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL mem_req: unexpected read of %h, no read required", paddr);
        end else checkOutput("mem_addr", 128'(paddr), 128'(exp_addr_q.pop_front()));
      end
    end
  end

  // Response monitor: random back-pressure, scoreboard pop, stability while stalled.
  initial begin
    bit   stalled = 0;
    rsp_t snap = '0, cur;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) begin
        cur = packRsp();
        if (stalled) checkOutput("rsp_stable", 128'(cur), 128'(snap));
        rsp_ready_i = !hold_ready && ($urandom_range(99, 0) < ready_pct);
        if (rsp_ready_i) begin
          stalled = 0;
          if (exp_rsp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL rsp_unexpected: got %h, no response required", cur);
          end else checkOutput("rsp", 128'(cur), 128'(exp_rsp_q.pop_front()));
        end else begin
          stalled = 1; snap = cur;
        end
      end else begin
        if (stalled) begin
          n_checks++;
          $display("[TB] FAIL rsp_valid_drop: valid 0 required 1");
        end
        stalled = 0;
        rsp_ready_i = 1'b0;
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [63:0] MSIPTP = 64'h1000_0000_0008_0000;
  localparam logic [63:0] WT_W0  = 64'h48D_1407;
  localparam logic [63:0] MR_W0  = (64'h123 << 7) | 64'h3;
  localparam logic [63:0] MR_W1  = (64'hABC << 10) | (64'h1 << 60) | 64'h155;

  initial begin
    rst_n = 0; req_valid_i = 0; req_gppn_i = '0; req_write_i = 0; flush_i = 0;
    msiptp_i = '0; msi_mask_i = '0; msi_pattern_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checkOutput("reset_ctrl", 128'({req_ready_o, mem_req_o, rsp_valid_o}), 128'(3'b100));
    checkOutput("reset_rsp", 128'(packRsp()), 128'(0));
    checkOutput("reset_addr", 128'(mem_addr_o), 128'(0));

    // Directed cases, zero-wait memory and no back-pressure.
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, WT_W0, 0, 0, 0), 1, 3); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h5, 64'h28000, WT_W0, 0, 0, 0), 1, 3); waitIdle();
    applyStimulus(mkTxn(52'h29005, 1, MSIPTP, 64'h7, 64'h28000, WT_W0, 0, 0, 0), 1, 1); waitIdle();
    applyStimulus(mkTxn(52'h28005, 0, MSIPTP, 64'h7, 64'h28000, WT_W0, 0, 0, 0), 1, 1); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, 64'h2000_0000_0008_0000, 64'h7, 64'h28000, WT_W0, 0, 0, 0), 1, 1); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, MR_W0, MR_W1, 0, 0), 1, 5); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, 64'h48D_1406, 0, 0, 0), 1, 3); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, 64'h48D_1405, 0, 0, 0), 1, 3); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, 64'h48D_1427, 0, 0, 0), 1, 3); waitIdle();
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, MR_W0, MR_W1, 0, 1), 1, 5); waitIdle();

    // Flush while waiting for word 0; the read returns three cycles later.
    dly_min = 3; dly_max = 3;
    applyStimulus(mkTxn(52'h28003, 1, MSIPTP, 64'h7, 64'h28000, WT_W0, 0, 0, 0), 0, 0);
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    checkOutput("drain_ready_a", 128'(req_ready_o), 128'(0));
    @(negedge clk); checkOutput("drain_ready_b", 128'(req_ready_o), 128'(0));
    @(negedge clk); checkOutput("drain_ready_c", 128'(req_ready_o), 128'(0));
    @(negedge clk); checkOutput("drain_done", 128'({req_ready_o, rsp_valid_o}), 128'(2'b10));
    waitIdle();
    dly_min = 0; dly_max = 0;

    // Hold the response for five cycles; the monitor checks it stays put.
    hold_ready = 1'b1;
    applyStimulus(mkTxn(52'h28005, 1, MSIPTP, 64'h7, 64'h28000, WT_W0, 0, 0, 0), 1, 3);
    repeat (5) @(negedge clk);
    hold_ready = 1'b0;
    waitIdle();

    // Randomized walks with random grant, read latency and back-pressure.
    gnt_pct = 70; dly_min = 0; dly_max = 3; ready_pct = 60;
    for (int i = 0; i < 300; i++) applyStimulus(randTxn(i), 1, 0);
    waitIdle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
